// File: rtl/store_narrow_16.sv
// Store narrower: splits a 32-bit byte/half/word store into beats on a 16-bit memory port.
// Optional STORE_ALIGN_CHECK_EN: reject misaligned half/word stores (no beats) and flag them on misalign.
module store_narrow_16 #(
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  output logic [1:0]        mem_be,
  output logic              busy,
  output logic              done
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t            state;
  logic              is_word_q;
  logic [ADDR_W-1:0] beat1_addr_q;
  logic [15:0]       hi_data_q;

  logic [ADDR_W-1:0] first_addr;
  logic [15:0]       first_wdata;
  logic [1:0]        first_be;
  logic              no_beat;
  logic              req_misalign;

  // First-beat decode straight from the request inputs, so BEAT0 presents it the cycle after accept.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    first_addr   = {req_addr[ADDR_W-1:1], 1'b0};
    first_wdata  = req_data[15:0];
    first_be     = 2'b11;
    no_beat      = 1'b0;
    req_misalign = 1'b0;
    case (size_t'(req_size))
      SZ_BYTE: begin
        first_wdata = {req_data[7:0], req_data[7:0]};
        first_be    = req_addr[0] ? 2'b10 : 2'b01;
      end
      SZ_HALF: begin
`ifdef STORE_ALIGN_CHECK_EN
        req_misalign = req_addr[0];
`endif
      end
      SZ_WORD: begin
        first_addr = {req_addr[ADDR_W-1:2], 2'b00};
`ifdef STORE_ALIGN_CHECK_EN
        req_misalign = (req_addr[1:0] != 2'b00);
`endif
      end
      default: no_beat = 1'b1;
    endcase
    if (req_misalign) no_beat = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the request holding registers are reset too; they are few flops and this keeps
      // every output and internal value defined straight out of reset.
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      is_word_q    <= 1'b0;
      beat1_addr_q <= '0;
      hi_data_q    <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      misalign     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_word_q    <= (size_t'(req_size) == SZ_WORD);
            beat1_addr_q <= {req_addr[ADDR_W-1:2], 2'b10};
            hi_data_q    <= req_data[31:16];
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            if (no_beat) begin
              state <= S_DONE;
              done  <= 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
              misalign <= req_misalign;
`endif
            end else begin
              state     <= S_BEAT0;
              mem_valid <= 1'b1;
              mem_addr  <= first_addr;
              mem_wdata <= first_wdata;
              mem_be    <= first_be;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
            if (is_word_q) begin
              state     <= S_BEAT1;
              mem_addr  <= beat1_addr_q;
              mem_wdata <= hi_data_q;
              mem_be    <= 2'b11;
            end else begin
              state     <= S_DONE;
              mem_valid <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= 2'b00;
              done      <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (mem_ready) begin
            state     <= S_DONE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 2'b00;
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
          misalign  <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_16.sv
// Randomised scoreboard bench for store_narrow_16: expected beats and done timing come from an
// arithmetic model of the narrowing rules; a negedge monitor pops and compares.
module tb_store_narrow_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        busy;
  logic        done;
`ifdef STORE_ALIGN_CHECK_EN
  logic        misalign;
`endif

  store_narrow_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy),
    .done      (done)
`ifdef STORE_ALIGN_CHECK_EN
    ,
    .misalign  (misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        last;
  } beat_t;

  beat_t beat_q[$];
  int    cyc = 0;
  int    exp_done_cyc = -1;
  bit    exp_mis = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      mem_ready = ($urandom_range(9) < 6);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: what the memory should see for one store, from plain address arithmetic.
  function automatic int model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                               output bit mis);
    logic [31:0] half_base, word_base;
    beat_t b;
    mis = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    mis = (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
`endif
    half_base = a - (a % 2);
    word_base = a - (a % 4);
    if (mis || s == 2'd3) return 0;
    if (s == 2'd0) begin
      b.addr  = half_base;
      b.wdata = 16'((d % 256) * 257);
      b.be    = ((a % 2) != 0) ? 2'd2 : 2'd1;
      b.last  = 1'b1;
      beat_q.push_back(b);
      return 1;
    end
    if (s == 2'd1) begin
      b.addr  = half_base;
      b.wdata = 16'(d % 65536);
      b.be    = 2'd3;
      b.last  = 1'b1;
      beat_q.push_back(b);
      return 1;
    end
    b.addr  = word_base;
    b.wdata = 16'(d % 65536);
    b.be    = 2'd3;
    b.last  = 1'b0;
    beat_q.push_back(b);
    b.addr  = word_base + 2;
    b.wdata = 16'(d / 65536);
    b.last  = 1'b1;
    beat_q.push_back(b);
    return 2;
  endfunction

  // Monitor: beat scoreboard, stall stability and done timing.
  bit    stall_prev = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      beat_t e;
      check("busy_vs_req_ready", busy, !req_ready);
      if (stall_prev) begin
        check("stall_valid_held", mem_valid, 1'b1);
        check("stall_addr_held", mem_addr, held.addr);
        check("stall_wdata_held", mem_wdata, held.wdata);
        check("stall_be_held", mem_be, held.be);
      end
      if (mem_valid) check("beat_addr_bit0", mem_addr[0], 1'b0);
      if (mem_valid && mem_ready) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = beat_q.pop_front();
          check("beat_addr", mem_addr, e.addr);
          check("beat_wdata", mem_wdata, e.wdata);
          check("beat_be", mem_be, e.be);
          if (e.last) exp_done_cyc = cyc + 1;
        end
      end
      if (cyc == exp_done_cyc) begin
        check("done_pulse", done, 1'b1);
`ifdef STORE_ALIGN_CHECK_EN
        check("misalign_on_done", misalign, exp_mis);
`endif
        exp_done_cyc = -1;
      end else begin
        check("no_stray_done", done, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
        check("misalign_idle", misalign, 1'b0);
`endif
      end
      stall_prev = mem_valid && !mem_ready;
      held.addr  = mem_addr;
      held.wdata = mem_wdata;
      held.be    = mem_be;
      held.last  = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit hold);
    int n = 0;
    int nb;
    bit mis;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    nb = model(a, d, s, mis);
    exp_mis = mis;
    if (nb == 0) exp_done_cyc = cyc + 1;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check("valid_after_accept", mem_valid, (nb > 0));
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && beat_q.size() == 0 && exp_done_cyc == -1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < 300), 1'b1);
  endtask

  initial begin
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_mem_be", mem_be, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);

    // Word with ready always high: beats at t+1, t+2, done t+3, ready again t+4.
    send(32'h100, 32'h1234_ABCD, 2'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("word_ready_low_in_done", req_ready, 1'b0);
    @(negedge clk);
    check("word_ready_back", req_ready, 1'b1);
    wait_idle();

    // Byte lanes, odd and even address.
    send(32'h203, 32'h0000_00EF, 2'd0, 1'b0);
    wait_idle();
    send(32'h202, 32'h0000_00EF, 2'd0, 1'b0);
    wait_idle();

    // Half with three stall cycles on its beat.
    mem_ready = 1'b0;
    send(32'h104, 32'h0000_5A5A, 2'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    wait_idle();

    // Reset asserted once BEAT0 has completed: the request is abandoned.
    send(32'h200, 32'hCAFE_F00D, 2'd2, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_mem_valid", mem_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_req_ready", req_ready, 1'b1);
    beat_q.delete();
    exp_done_cyc = -1;
    repeat (2) @(negedge clk);
    check("rst_hold_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);
    send(32'h300, 32'h0000_0077, 2'd0, 1'b0);
    wait_idle();

    // Odd-address half: forced-aligned beat, or rejected with misalign.
    send(32'h101, 32'h0000_BEEF, 2'd1, 1'b0);
    wait_idle();

    // Back-to-back with req_valid held high, including a reserved size.
    send(32'h10, 32'h1122_3344, 2'd0, 1'b1);
    send(32'h20, 32'h5566_7788, 2'd2, 1'b1);
    send(32'h30, 32'h0000_0099, 2'd3, 1'b1);
    req_valid = 1'b0;
    wait_idle();

    // Random traffic with random memory back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send($urandom, $urandom, 2'($urandom_range(3)), ($urandom_range(1) == 1));
      if ($urandom_range(3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_idle();
    rand_ready = 1'b0;
    check("scoreboard_empty", beat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
